// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory arbiter: state encoding, the
// full-word byte-enable constant and the byte-lane merge used for partial stores.
package dm_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StAck  = 2'd3
  } dm_state_e;

  localparam logic [3:0] BE_FULL = 4'b1111;

  function automatic logic [31:0] merge_word(input logic [3:0]  be,
                                             input logic [31:0] wdata,
                                             input logic [31:0] rdata);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the port that did not win last time
// is granted; rr_last resets to 1 so port 0 wins the first tie.
module dm_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic rr_last_q;

  always_comb begin
    gnt_valid_o = en_i & (|req_i);
    if (req_i == 2'b11) begin
      gnt_idx_o = ~rr_last_q;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= 1'b1;
    end else if (gnt_valid_o) begin
      rr_last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the word-wide data memory between the MEM stage (port 0) and the
// loader (port 1); byte-enable stores become read-modify-write sequences.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [3:0]        r0_be,
  input  logic [31:0]       r0_wdata,
  input  logic [31:0]       r0_pc,
  output logic              r0_ack,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [3:0]        r1_be,
  input  logic [31:0]       r1_wdata,
  input  logic [31:0]       r1_pc,
  output logic              r1_ack,
  output logic [31:0]       r1_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_we,
  output logic [31:0]       dm_pc,
  input  logic [31:0]       dm_rdata,
  output logic              busy
);

  localparam logic [1:0]        LatLast  = 2'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] WordMask = {{(ADDR_W-2){1'b1}}, 2'b00};

  dm_state_e         state_q, state_d;
  logic              gnt_valid, gnt_idx;
  logic              port_q, port_d;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q, rbuf_q;
  logic [1:0]        lat_q, lat_d;
  logic              sel_we;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata, sel_pc;
  logic [ADDR_W-1:0] sel_addr;
  logic              rd_done;
  logic [31:0]       wr_word;

  logic [ADDR_W-1:0] dm_addr_q;
  logic [31:0]       dm_wdata_q, dm_pc_q, r0_rdata_q, r1_rdata_q;
  logic              dm_we_q, r0_ack_q, r1_ack_q;

  dm_rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       ({r1_req, r0_req}),
    .en_i        (state_q == StIdle),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    sel_we    = gnt_idx ? r1_we    : r0_we;
    sel_be    = gnt_idx ? r1_be    : r0_be;
    sel_wdata = gnt_idx ? r1_wdata : r0_wdata;
    sel_pc    = gnt_idx ? r1_pc    : r0_pc;
    sel_addr  = gnt_idx ? r1_addr  : r0_addr;
  end

  assign rd_done = (state_q == StRd) && (lat_q == LatLast);
  assign port_d  = gnt_valid ? gnt_idx : port_q;

  // Full stores enter WR straight from IDLE; partial stores merge the word
  // arriving on dm_rdata as RD completes (the same value rbuf captures).
  assign wr_word = (state_q == StIdle) ? merge_word(sel_be, sel_wdata, rbuf_q)
                                       : merge_word(be_q, wdata_q, dm_rdata);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      StIdle: begin
        lat_d = 2'd0;
        if (gnt_valid) begin
          if (!sel_we) begin
            state_d = StRd;
          end else if (sel_be == BE_FULL) begin
            state_d = StWr;
          end else if (sel_be == 4'b0000) begin
            state_d = StAck;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (rd_done) begin
          state_d = we_q ? StWr : StAck;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StWr:    state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lat_q      <= 2'd0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      dm_addr_q  <= '0;
      dm_pc_q    <= '0;
      dm_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      r0_ack_q   <= 1'b0;
      r1_ack_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      port_q   <= port_d;
      dm_we_q  <= (state_d == StWr);
      r0_ack_q <= (state_d == StAck) && !port_d;
      r1_ack_q <= (state_d == StAck) && port_d;
      if (gnt_valid) begin
        we_q      <= sel_we;
        be_q      <= sel_be;
        wdata_q   <= sel_wdata;
        dm_addr_q <= sel_addr & WordMask;
        dm_pc_q   <= sel_pc;
      end
      if (rd_done) begin
        rbuf_q <= dm_rdata;
        if (!we_q && !port_q) r0_rdata_q <= dm_rdata;
        if (!we_q && port_q)  r1_rdata_q <= dm_rdata;
      end
      if ((state_d == StWr) && (state_q != StWr)) begin
        dm_wdata_q <= wr_word;
      end
    end
  end

  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign dm_we    = dm_we_q;
  assign dm_pc    = dm_pc_q;
  assign r0_ack   = r0_ack_q;
  assign r1_ack   = r1_ack_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: requests are queued as issued, and a monitor
// replays each acked transaction against a word-array reference memory.
module tb_dm_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] pc    [2];
  logic        r0_ack, r1_ack, dm_we, busy;
  logic [31:0] r0_rdata, r1_rdata, dm_addr, dm_wdata, dm_pc, dm_rdata;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  txn_t q0[$], q1[$];
  int   ack_order[$];
  int   checks = 0;
  int   errors = 0;
  int   bcnt = 0;
  int   we_seen = 0;
  logic [31:0] w_data, w_addr, w_pc;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .r0_req   (req[0]),
    .r0_we    (we[0]),
    .r0_addr  (addr[0]),
    .r0_be    (be[0]),
    .r0_wdata (wdata[0]),
    .r0_pc    (pc[0]),
    .r0_ack   (r0_ack),
    .r0_rdata (r0_rdata),
    .r1_req   (req[1]),
    .r1_we    (we[1]),
    .r1_addr  (addr[1]),
    .r1_be    (be[1]),
    .r1_wdata (wdata[1]),
    .r1_pc    (pc[1]),
    .r1_ack   (r1_ack),
    .r1_rdata (r1_rdata),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_pc    (dm_pc),
    .dm_rdata (dm_rdata),
    .busy     (busy)
  );

  // Asynchronous-read memory: RD_LAT=1 means dm_rdata is sampled one edge after dm_addr.
  assign dm_rdata = mem[dm_addr[9:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic score(input int p);
    txn_t        t;
    logic [31:0] m, merged, aligned;
    int          idx, exp_we, lat;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      chk("unexpected_ack", 32'(p), 32'hFFFF_FFFF);
      return;
    end
    t       = (p == 0) ? q0.pop_front() : q1.pop_front();
    idx     = int'(t.addr[9:2]);
    aligned = {t.addr[31:2], 2'b00};
    exp_we  = 0;
    if (!t.we) begin
      lat = 2;
      chk("rdata", (p == 0) ? r0_rdata : r1_rdata, ref_mem[idx]);
    end else if (t.be == 4'h0) begin
      lat = 1;
    end else begin
      lat    = (t.be == 4'hF) ? 2 : 3;
      exp_we = 1;
      m      = {{8{t.be[3]}}, {8{t.be[2]}}, {8{t.be[1]}}, {8{t.be[0]}}};
      merged = (t.wdata & m) | (ref_mem[idx] & ~m);
      ref_mem[idx] = merged;
      chk("wr_data", w_data, merged);
      chk("wr_addr", w_addr, aligned);
      chk("wr_pc", w_pc, t.pc);
    end
    chk("we_pulses", 32'(we_seen), 32'(exp_we));
    chk("latency", 32'(bcnt), 32'(lat));
    chk("ack_addr", dm_addr, aligned);
    chk("ack_pc", dm_pc, t.pc);
    ack_order.push_back(p);
    we_seen = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        bcnt    = 0;
        we_seen = 0;
      end else begin
        if (busy) bcnt++;
        else bcnt = 0;
        if (dm_we) begin
          we_seen++;
          w_data = dm_wdata;
          w_addr = dm_addr;
          w_pc   = dm_pc;
        end
        if (r0_ack || r1_ack) begin
          chk("ack_excl", 32'(r0_ack & r1_ack), 32'd0);
          score(r1_ack ? 1 : 0);
        end
      end
    end
  end

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] c, input bit scram);
    txn_t t;
    bit   got;
    t = '{we: w, addr: a, be: b, wdata: d, pc: c};
    if (p == 0) q0.push_back(t);
    else q1.push_back(t);
    req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = b; wdata[p] = d; pc[p] = c;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((p == 0) ? r0_ack : r1_ack) begin
        got = 1'b1;
        break;
      end
      // Inputs after the grant must not affect the transaction, and a dropped req
      // must not cancel it.
      if (scram && busy) begin
        req[p] = 1'($urandom_range(0, 1)); we[p] = ~w; addr[p] = $urandom;
        be[p] = 4'($urandom); wdata[p] = $urandom; pc[p] = $urandom;
      end
    end
    req[p] = 1'b0;
    if (!got) chk("ack_timeout", 32'(p), 32'hFFFF_FFFF);
  endtask

  task automatic rand_port(input int p, input int n);
    logic [3:0] b;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0:       b = 4'h0;
        1:       b = 4'hF;
        default: b = 4'($urandom_range(1, 14));
      endcase
      issue(p, 1'($urandom_range(0, 1)), 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
            b, $urandom, $urandom, 1'b0);
    end
  endtask

  initial begin
    int diff;
    reset = 1'b1;
    req = 2'b00; we = 2'b00;
    for (int p = 0; p < 2; p++) begin
      be[p] = 4'h0; addr[p] = '0; wdata[p] = '0; pc[p] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h5A00_0000 ^ (i * 32'h0101_0107);
      ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0101_0107);
    end
    mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_acks", 32'({r0_ack, r1_ack}), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_dm_pc", dm_pc, 32'd0);
    chk("rst_rdata0", r0_rdata, 32'd0);
    chk("rst_rdata1", r1_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(0, 1'b0, 32'h12, 4'h0, 32'h0, 32'h100, 1'b1);
    chk("read_dead", r0_rdata, 32'hDEAD_BEEF);
    issue(1, 1'b1, 32'h20, 4'b0010, 32'h0000_AA00, 32'h2004, 1'b1);
    chk("pstore_mem", mem[8], 32'h1122_AA44);
    issue(0, 1'b1, 32'h40, 4'hF, 32'hCAFE_F00D, 32'h300, 1'b1);
    issue(1, 1'b0, 32'h40, 4'h0, 32'h0, 32'h304, 1'b0);
    chk("fstore_read", r1_rdata, 32'hCAFE_F00D);
    issue(0, 1'b1, 32'h10, 4'h0, 32'h1234_5678, 32'h400, 1'b1);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'h404, 1'b0);
    chk("noop_read", r0_rdata, 32'hDEAD_BEEF);

    // Reset while a partial store sits in RD: no write, no ack.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h24; be[1] = 4'b0100;
    wdata[1] = 32'h00FF_0000; pc[1] = 32'h500;
    for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
    chk("abort_in_rd", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we", 32'(dm_we), 32'd0);
    chk("abort_acks", 32'({r0_ack, r1_ack}), 32'd0);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_mem", mem[9], ref_mem[9]);
    ack_order.delete();
    reset = 1'b0;

    fork
      begin
        issue(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'h600, 1'b0);
        issue(0, 1'b0, 32'h24, 4'h0, 32'h0, 32'h604, 1'b0);
      end
      issue(1, 1'b1, 32'h28, 4'b1000, 32'h7700_0000, 32'h608, 1'b0);
    join
    chk("rr_count", 32'(ack_order.size()), 32'd3);
    if (ack_order.size() == 3) begin
      chk("rr_first", 32'(ack_order[0]), 32'd0);
      chk("rr_second", 32'(ack_order[1]), 32'd1);
      chk("rr_third", 32'(ack_order[2]), 32'd0);
    end

    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (3) @(negedge clk);
    chk("queues_empty", 32'(q0.size() + q1.size()), 32'd0);
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("mem_final", 32'(diff), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Sequences and shares the single-port word data memory between two requesters: port 0 is the pipeline MEM stage and port 1 is the debug/DMA loader.
- Runs round-robin arbitration with a req/ack handshake.
- Converts byte-enable stores into read-modify-write cycles, because the memory array writes whole words only.
- Sits between the MEM stage or loader and the data memory. It is the only driver of the memory's address, write-data, write-enable and PC inputs.

Parameters:
- ADDR_W, 32, byte address width.
- RD_LAT, 1, cycles between driving dm_addr and dm_rdata being sampled. Legal values are 1..3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- r0_req  in  1  port 0 request. Held high until r0_ack.
- r0_we  in  1  port 0 write (1) or read (0)
- r0_addr  in  ADDR_W  port 0 byte address. Bits [1:0] are ignored.
- r0_be  in  4  port 0 byte enables. Bit i selects byte lane [8i+7:8i].
- r0_wdata  in  32  port 0 store data, lane-aligned
- r0_pc  in  32  port 0 PC, forwarded for the memory write log
- r0_ack  out  1  one-cycle completion pulse
- r0_rdata  out  32  port 0 read word. Valid while r0_ack=1.
- r1_req, r1_we, r1_addr, r1_be, r1_wdata, r1_pc, r1_ack, r1_rdata: same definitions for port 1.
- dm_addr  out  ADDR_W  memory address, {addr[ADDR_W-1:2],2'b00}
- dm_wdata  out  32  merged write word
- dm_we  out  1  memory write enable. High for exactly one cycle per write.
- dm_pc  out  32  PC of the granted requester
- dm_rdata  in  32  memory read word
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous) forces:
  - state to IDLE;
  - dm_we, r0_ack, r1_ack and busy to 0;
  - dm_addr, dm_wdata, dm_pc, r0_rdata and r1_rdata to 0;
  - rr_last to 1, so port 0 wins the first tie.
- A reset asserted mid-transaction aborts it: no ack is issued and no write occurs.
- States:
  - IDLE
  - RD: addr driven, wait RD_LAT cycles, then capture dm_rdata into rbuf
  - WR: dm_we=1 for one cycle
  - ACK: pulse the granted ack
- Grant, taken in IDLE:
  - If only one req is high, that port is granted.
  - If both are high, the port not equal to rr_last is granted.
  - rr_last is updated on every grant.
  - The granted port's we, addr, be, wdata and pc are latched on the grant edge. Changes to requester inputs after the grant are ignored.
- Transition selection on grant:
  - read: IDLE -> RD -> ACK
  - write with be=4'b1111: IDLE -> WR -> ACK (no read)
  - write with be=0: IDLE -> ACK (no memory access)
  - any other write (partial store): IDLE -> RD -> WR -> ACK
- Merge rule: for each lane i, dm_wdata lane i = be[i] ? wdata lane i : rbuf lane i.
- Latencies, counted from the grant edge to ack high, with RD_LAT=1:
  - read: 2 cycles
  - full write: 2 cycles
  - partial write: 3 cycles
  - no-op write: 1 cycle
- Ack:
  - rN_ack is registered, high for exactly one cycle (the ACK state), and never high for both ports at once.
  - For reads, rN_rdata = rbuf and holds until the next read on that port.
- Handshake:
  - The requester deasserts req on the edge after it sees ack. ACK always returns to IDLE.
  - A req still high in IDLE is treated as a new transaction.
  - A req dropped after grant does not cancel the transaction; it completes and acks.
- No new grant is made while busy=1. The other port waits, with its req held high.
- dm_addr and dm_pc hold the latched values from the grant through ACK, and are unchanged in IDLE.
- dm_we is 0 in every state except WR.

Decomposition:
- A shared package dm_pkg holds:
  - the state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2, ACK=2'd3);
  - the constant BE_FULL=4'b1111;
  - the merge function.
- One sub-module is natural: dm_rr_arb2, a 2-way round-robin arbiter containing the rr_last register and producing a grant index and grant valid.

Test Plan:
- Read from port 0 only: memory word 0x10 = 0xDEADBEEF, r0 read of addr 0x12 -> dm_addr=0x10, r0_ack 2 cycles after grant, r0_rdata=0xDEADBEEF, dm_we never high.
- Partial store: word 0x20 = 0x11223344, r1 write be=4'b0010 wdata=0x0000AA00 -> exactly one dm_we cycle with dm_wdata=0x1122AA44 and dm_pc=r1_pc, r1_ack on cycle 3.
- Contention: both req high from reset -> grant order port 0, then port 1, then port 0 while both are held high. Acks alternate, never simultaneous.
- Full store: be=4'b1111 wdata=0xCAFEF00D at addr 0x40 -> no RD state (busy for 2 cycles), dm_we for one cycle; a subsequent read returns 0xCAFEF00D.
- No-op store: be=4'b0000 -> ack 1 cycle after grant, dm_we stays 0, memory unchanged.
- Reset during WR-pending partial store: assert reset while in RD -> state IDLE, dm_we=0 and ack=0 immediately. Memory unchanged; the first tie after reset goes to port 0.
